// File: rtl/weight_stream_feeder.sv
// Host-to-SRAM weight feeder: input FIFO, strobed write sequencer and
// ping-pong bank occupancy tracking with stall on a full target bank.
module weight_stream_feeder #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_valid,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  input  logic [1:0]        bank_release,
  output logic              new_weight,
  output logic [DATA_W-1:0] weight_data,
  output logic              bank_sel,
  output logic [ADDR_W-1:0] write_addr,
  output logic [1:0]        bank_full,
  output logic              busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t            state, next_state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, d_wr_ptr, d_rd_ptr;
  logic [CNT_W-1:0]  count, d_count;
  logic              push, pop;
  logic [1:0]        set_mask;
  logic              d_new_weight, d_bank_sel, d_busy, d_host_ready;
  logic [DATA_W-1:0] d_weight_data;
  logic [ADDR_W-1:0] d_write_addr;
  logic [1:0]        d_bank_full;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      new_weight  <= 1'b0;
      weight_data <= '0;
      bank_sel    <= 1'b0;
      write_addr  <= '0;
      bank_full   <= 2'b00;
      busy        <= 1'b0;
      host_ready  <= 1'b1;
    end else begin
      state       <= next_state;
      wr_ptr      <= d_wr_ptr;
      rd_ptr      <= d_rd_ptr;
      count       <= d_count;
      new_weight  <= d_new_weight;
      weight_data <= d_weight_data;
      bank_sel    <= d_bank_sel;
      write_addr  <= d_write_addr;
      bank_full   <= d_bank_full;
      busy        <= d_busy;
      host_ready  <= d_host_ready;
    end
  end

  // FIFO storage; contents are discarded on reset through the pointers
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= host_data;
  end

  // Next-state and next-output logic
  always_comb begin
    next_state    = state;
    pop           = 1'b0;
    set_mask      = 2'b00;
    d_new_weight  = 1'b0;
    d_weight_data = weight_data;
    d_bank_sel    = bank_sel;
    d_write_addr  = write_addr;
    push          = host_valid && host_ready;

    case (state)
      IDLE: begin
        if ((count != '0) && !bank_full[bank_sel]) begin
          pop           = 1'b1;
          d_weight_data = mem[rd_ptr];
          d_new_weight  = 1'b1;
          next_state    = PULSE;
        end
      end
      PULSE: next_state = GAP;
      GAP: begin
        if (write_addr == ADDR_LAST) begin
          set_mask[bank_sel] = 1'b1;
          d_bank_sel         = ~bank_sel;
          d_write_addr       = '0;
        end else begin
          d_write_addr = write_addr + ADDR_W'(1);
        end
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase

    // A set on the same bank as a release wins
    d_bank_full  = (bank_full & ~bank_release) | set_mask;
    d_wr_ptr     = push ? wr_ptr + PTR_W'(1) : wr_ptr;
    d_rd_ptr     = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    d_count      = count + CNT_W'(push) - CNT_W'(pop);
    d_host_ready = (d_count != CNT_FULL);
    d_busy       = (d_count != '0) || (next_state != IDLE);
  end

endmodule

// File: tb/tb_weight_stream_feeder.sv
// Directed bench for weight_stream_feeder with an in-order scoreboard and
// an independent bank/address sequence model.
module tb_weight_stream_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       host_valid;
  logic [7:0] host_data;
  logic       host_ready;
  logic [1:0] bank_release;
  logic       new_weight;
  logic [7:0] weight_data;
  logic       bank_sel;
  logic [3:0] write_addr;
  logic [1:0] bank_full;
  logic       busy;

  weight_stream_feeder #(.DATA_W(8), .ADDR_W(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .host_valid(host_valid), .host_data(host_data),
    .host_ready(host_ready), .bank_release(bank_release), .new_weight(new_weight),
    .weight_data(weight_data), .bank_sel(bank_sel), .write_addr(write_addr),
    .bank_full(bank_full), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc = 0;
  int last_cyc = -1;
  int strobe_cnt = 0;
  int valid_pct = 100;
  int rel_pct = 0;
  int rel_cd = 0;
  bit exact_spacing = 0;
  bit hold_pending = 0;
  logic [7:0] last_data;
  logic [1:0] rel_now = 2'b00;
  logic [1:0] gap_release = 2'b00;
  logic       exp_bank;
  logic [3:0] exp_addr;
  logic [7:0] host_q[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    host_q.delete();
    exp_q.delete();
    exp_bank = 1'b0;
    exp_addr = 4'd0;
    last_cyc = -1;
    strobe_cnt = 0;
    hold_pending = 0;
    rel_cd = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    host_valid = 1'b0;
    host_data = 8'h00;
    bank_release = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_strobe();
    logic [7:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    chk("data_order", 32'(weight_data), 32'(e));
    chk("bank_seq", 32'(bank_sel), 32'(exp_bank));
    chk("addr_seq", 32'(write_addr), 32'(exp_addr));
    chk("strobe_to_full_bank", 32'(bank_full[bank_sel]), 32'd0);
    if (last_cyc >= 0)
      chk("spacing", exact_spacing ? 32'((cyc - last_cyc) == 3) : 32'((cyc - last_cyc) >= 3), 32'd1);
    if (exp_addr == 4'hF) exp_bank = ~exp_bank;
    exp_addr = exp_addr + 4'd1;
    if (gap_release != 2'b00 && write_addr == 4'hF) rel_cd = 2;
    last_cyc = cyc;
    last_data = weight_data;
    hold_pending = 1;
    strobe_cnt++;
  endtask

  // One iteration: drive inputs, clock, then observe 1ns after the edge
  task automatic run(input int max_cyc, input int stop_at);
    int n;
    bit acc;
    logic [1:0] rel;
    n = 0;
    while (n < max_cyc && !(stop_at >= 0 && strobe_cnt >= stop_at)) begin
      rel = rel_now;
      rel_now = 2'b00;
      if (rel_cd == 1) rel = rel | gap_release;
      if (rel_cd > 0) rel_cd--;
      if (rel_pct > 0 && $urandom_range(99) < rel_pct) rel = rel | (bank_full & 2'($urandom));
      bank_release = rel;
      host_valid = (host_q.size() > 0) && ($urandom_range(99) < valid_pct);
      host_data = host_valid ? host_q[0] : 8'h00;
      acc = host_valid && host_ready;
      @(posedge clk); #1;
      cyc++;
      n++;
      if (acc) exp_q.push_back(host_q.pop_front());
      bank_release = 2'b00;
      host_valid = 1'b0;
      if (hold_pending && !new_weight) begin
        chk("data_hold", 32'(weight_data), 32'(last_data));
        hold_pending = 0;
      end
      if (new_weight) check_strobe();
    end
    if (stop_at >= 0 && strobe_cnt < stop_at) chk("strobe_timeout", 32'(strobe_cnt), 32'(stop_at));
  endtask

  initial begin
    do_reset();
    chk("rst_new_weight", 32'(new_weight), 32'd0);
    chk("rst_weight_data", 32'(weight_data), 32'd0);
    chk("rst_bank_sel", 32'(bank_sel), 32'd0);
    chk("rst_write_addr", 32'(write_addr), 32'd0);
    chk("rst_bank_full", 32'(bank_full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_host_ready", 32'(host_ready), 32'd1);

    // Single word latency: accepted at t=0, strobe at t=2 only
    host_q.push_back(8'h11);
    run(1, -1);
    chk("t1_strobe_early", 32'(new_weight), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    run(1, -1);
    chk("t1_strobe", 32'(new_weight), 32'd1);
    chk("t1_data", 32'(weight_data), 32'h11);
    chk("t1_addr", 32'(write_addr), 32'd0);
    run(1, -1);
    chk("t1_strobe_gap", 32'(new_weight), 32'd0);
    run(1, -1);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // Fill bank 0 with a continuous stream
    do_reset();
    exact_spacing = 1;
    for (int i = 0; i < 16; i++) host_q.push_back(8'(i));
    run(200, 16);
    run(2, -1);
    chk("t2_bank_full", 32'(bank_full), 32'h1);
    chk("t2_bank_sel", 32'(bank_sel), 32'd1);
    chk("t2_addr", 32'(write_addr), 32'd0);

    // Both banks full: stall with FIFO full and host held
    do_reset();
    for (int i = 0; i < 40; i++) host_q.push_back(8'(i));
    run(300, 32);
    exact_spacing = 0;
    run(12, -1);
    chk("t3_strobes_stopped", 32'(strobe_cnt), 32'd32);
    chk("t3_bank_full", 32'(bank_full), 32'h3);
    chk("t3_host_ready", 32'(host_ready), 32'd0);
    chk("t3_host_pending", 32'(host_q.size()), 32'd4);
    chk("t3_busy", 32'(busy), 32'd1);
    rel_now = 2'b01;
    run(1, -1);
    run(20, 33);
    chk("t3_resume_data", 32'(last_data), 32'd32);
    chk("t3_resume_bank", 32'(bank_sel), 32'd0);
    chk("t3_resume_addr", 32'(write_addr), 32'd0);
    run(100, 40);
    run(2, -1);
    chk("t3_after_bank_full", 32'(bank_full), 32'h2);
    chk("t3_after_addr", 32'(write_addr), 32'd8);

    // Release bank 1 in the GAP that fills bank 0, then a release of an empty bank
    gap_release = 2'b10;
    for (int i = 40; i < 48; i++) host_q.push_back(8'(i));
    run(100, 48);
    run(2, -1);
    gap_release = 2'b00;
    chk("t4_cross_full", 32'(bank_full), 32'h1);
    chk("t4_bank_sel", 32'(bank_sel), 32'd1);
    rel_now = 2'b10;
    run(1, -1);
    chk("t4_empty_release", 32'(bank_full), 32'h1);
    rel_now = 2'b01;
    run(1, -1);
    chk("t4_release0", 32'(bank_full), 32'h0);

    // Reset during PULSE with words queued
    for (int i = 0; i < 5; i++) host_q.push_back(8'hA0 + 8'(i));
    run(50, 50);
    chk("t5_in_pulse", 32'(new_weight), 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_new_weight", 32'(new_weight), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_bank_sel", 32'(bank_sel), 32'd0);
    chk("t5_addr", 32'(write_addr), 32'd0);
    do_reset();
    host_q.push_back(8'h5A);
    run(10, 1);
    chk("t5_post_data", 32'(weight_data), 32'h5A);
    chk("t5_post_bank", 32'(bank_sel), 32'd0);
    chk("t5_post_addr", 32'(write_addr), 32'd0);

    // Random host gaps, back-pressure and releases
    do_reset();
    valid_pct = 60;
    rel_pct = 15;
    for (int i = 0; i < 1000; i++) host_q.push_back(8'($urandom));
    run(30000, 1000);
    run(2, -1);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t6_host_drained", 32'(host_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
